// File: rtl/cxl_pkg.sv
// Shared types and default widths for the CXL get-request path.
package cxl_pkg;

   localparam int CXL_ID_W  = 5;
   localparam int CXL_AMT_W = 32;

   typedef struct packed {
      logic [CXL_ID_W-1:0]  id;
      logic [CXL_AMT_W-1:0] amount;
   } cxl_get_req_t;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } cxl_getq_state_e;

endpackage

// File: rtl/cxl_req_fifo.sv
// Synchronous DEPTH-entry FIFO of get requests; count is full-range occupancy.
module cxl_req_fifo
   import cxl_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  cxl_get_req_t i_data,
   input  logic         i_pop,
   output cxl_get_req_t o_head,
   output logic [CW-1:0] o_count,
   output logic         o_full,
   output logic         o_empty
);

   cxl_get_req_t  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   // Storage is not cleared on reset; zeroing the pointers discards its contents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/cxl_get_req_queue.sv
// Buffers client get requests and issues them one at a time to the get stage,
// holding each until ack or timeout and reporting completion on a done strobe.
//
// state    | meaning
// IDLE     | no request outstanding; pops the FIFO head when one is queued
// WAIT_ACK | request presented on out_*; waits for ack or TIMEOUT cycles
module cxl_get_req_queue
   import cxl_pkg::*;
#(
   parameter  int DEPTH   = 8,
   parameter  int ID_W    = CXL_ID_W,
   parameter  int AMT_W   = CXL_AMT_W,
   parameter  int TIMEOUT = 16,
   localparam int CW      = $clog2(DEPTH) + 1,
   localparam int TW      = $clog2(TIMEOUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ID_W-1:0]  in_client_id,
   input  logic [AMT_W-1:0] in_amount,
   output logic             out_valid,
   output logic [ID_W-1:0]  out_client_id,
   output logic [AMT_W-1:0] out_amount,
   input  logic             ack,
   output logic             done_valid,
   output logic [ID_W-1:0]  done_client_id,
   output logic             done_ok,
   output logic [CW-1:0]    count
);

   cxl_getq_state_e r_state;
   cxl_getq_state_e w_state_nxt;
   logic [TW-1:0]   r_timer;
   logic            r_out_valid;
   logic [ID_W-1:0] r_out_id;
   logic [AMT_W-1:0] r_out_amt;
   logic            r_done_valid;
   logic [ID_W-1:0] r_done_id;
   logic            r_done_ok;

   cxl_get_req_t    w_push_req;
   cxl_get_req_t    w_head;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic            w_tmo;

   assign w_push_req.id     = in_client_id;
   assign w_push_req.amount = in_amount;
   assign in_ready          = ~w_full;
   assign w_pop             = (r_state == IDLE) & ~w_empty;
   assign w_tmo             = (r_timer == TW'(TIMEOUT - 1));

   cxl_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (in_valid),
      .i_data  (w_push_req),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // An ack on the timeout edge wins: it is checked first.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (!w_empty) w_state_nxt = WAIT_ACK;
         WAIT_ACK: if (ack || w_tmo) w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_timer      <= '0;
         r_out_valid  <= 1'b0;
         r_out_id     <= '0;
         r_out_amt    <= '0;
         r_done_valid <= 1'b0;
         r_done_id    <= '0;
         r_done_ok    <= 1'b0;
      end else begin
         r_done_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_out_id    <= w_head.id;
                  r_out_amt   <= w_head.amount;
                  r_out_valid <= 1'b1;
                  r_timer     <= '0;
               end
            end
            WAIT_ACK: begin
               if (ack || w_tmo) begin
                  r_out_valid  <= 1'b0;
                  r_done_valid <= 1'b1;
                  r_done_ok    <= ack;
                  r_done_id    <= r_out_id;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            default: r_out_valid <= 1'b0;
         endcase
      end
   end

   assign out_valid      = r_out_valid;
   assign out_client_id  = r_out_id;
   assign out_amount     = r_out_amt;
   assign done_valid     = r_done_valid;
   assign done_client_id = r_done_id;
   assign done_ok        = r_done_ok;

endmodule

// File: tb/tb_cxl_get_req_queue.sv
// Cycle-stepped bench for cxl_get_req_queue against a queue-based reference model.
module tb_cxl_get_req_queue;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [4:0]  in_client_id = '0;
   logic [31:0] in_amount = '0;
   logic        ack = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [4:0]  out_client_id;
   logic [31:0] out_amount;
   logic        done_valid;
   logic [4:0]  done_client_id;
   logic        done_ok;
   logic [3:0]  count;

   cxl_get_req_queue #(
      .DEPTH   (DEPTH),
      .ID_W    (5),
      .AMT_W   (32),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_client_id   (in_client_id),
      .in_amount      (in_amount),
      .out_valid      (out_valid),
      .out_client_id  (out_client_id),
      .out_amount     (out_amount),
      .ack            (ack),
      .done_valid     (done_valid),
      .done_client_id (done_client_id),
      .done_ok        (done_ok),
      .count          (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  id;
      logic [31:0] amt;
   } req_s;

   // Reference model: pending requests, the one in flight, how long it has waited.
   req_s       m_q[$];
   bit         m_busy;
   req_s       m_cur;
   int         m_wait;
   bit         m_done_v;
   bit         m_done_ok;
   logic [4:0] m_done_id;
   bit         m_clean;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_edge(input bit v, input logic [4:0] id, input logic [31:0] amt,
                             input bit a, input bit rb);
      bit ready;
      ready = (m_q.size() < DEPTH);
      if (!rb) begin
         m_q.delete();
         m_busy    = 0;
         m_wait    = 0;
         m_done_v  = 0;
         m_done_ok = 0;
         m_done_id = '0;
         m_cur.id  = '0;
         m_cur.amt = '0;
         m_clean   = 1;
         return;
      end
      m_done_v = 0;
      if (m_busy) begin
         if (a || m_wait == TIMEOUT) begin
            m_busy    = 0;
            m_done_v  = 1;
            m_done_ok = a;
            m_done_id = m_cur.id;
            m_clean   = 0;
         end else begin
            m_wait++;
         end
      end else if (m_q.size() != 0) begin
         m_cur   = m_q.pop_front();
         m_busy  = 1;
         m_wait  = 1;
         m_clean = 0;
      end
      if (v && ready) m_q.push_back('{id, amt});
   endtask

   task automatic compare_all();
      chk("out_valid", 64'(out_valid), 64'(m_busy));
      chk("in_ready", 64'(in_ready), 64'(m_q.size() < DEPTH));
      chk("count", 64'(count), 64'(m_q.size()));
      chk("done_valid", 64'(done_valid), 64'(m_done_v));
      if (m_busy || m_clean) begin
         chk("out_client_id", 64'(out_client_id), 64'(m_cur.id));
         chk("out_amount", 64'(out_amount), 64'(m_cur.amt));
      end
      if (m_done_v || m_clean) begin
         chk("done_client_id", 64'(done_client_id), 64'(m_done_id));
         chk("done_ok", 64'(done_ok), 64'(m_done_ok));
      end
   endtask

   task automatic step(input bit v, input logic [4:0] id, input logic [31:0] amt,
                       input bit a, input bit rb);
      in_valid     = v;
      in_client_id = id;
      in_amount    = amt;
      ack          = a;
      rst_n        = rb;
      @(posedge clk);
      model_edge(v, id, amt, a, rb);
      #1;
      compare_all();
   endtask

   function automatic logic [31:0] rand_amt();
      return ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
   endfunction

   initial begin
      logic [4:0]  rid;
      logic [31:0] ramt;
      bit          acc;
      bit          saw_full;

      // Reset, then idle with ack toggling.
      step(0, '0, '0, 0, 0);
      step(0, '0, '0, 1, 0);
      for (int i = 0; i < 5; i++) step(0, '0, '0, bit'(i % 2), 1);

      // Single request, ack two cycles after issue.
      step(1, 5'h1B, 32'hC5, 0, 1);
      step(0, '0, '0, 0, 1);
      step(0, '0, '0, 0, 1);
      step(0, '0, '0, 0, 1);
      step(0, '0, '0, 1, 1);
      step(0, '0, '0, 0, 1);

      // Three back-to-back requests, ack held high.
      step(1, 5'h1B, 32'hC5, 0, 1);
      step(1, 5'h08, 32'hC5, 0, 1);
      step(1, 5'h08, 32'h20C5, 0, 1);
      for (int i = 0; i < 12; i++) step(0, '0, '0, 1, 1);

      // Overfill with no ack: in_valid held until accepted; every request times out.
      saw_full = 0;
      for (int k = 0; k < DEPTH + 2; k++) begin
         rid  = 5'($urandom);
         ramt = rand_amt();
         for (int t = 0; t < 100; t++) begin
            acc = (m_q.size() < DEPTH);
            if (!acc) saw_full = 1;
            step(1, rid, ramt, 0, 1);
            if (acc) break;
         end
      end
      chk("queue_reached_full", 64'(saw_full), 64'(1));
      for (int i = 0; i < (DEPTH + 2) * (TIMEOUT + 1) + 4; i++) step(0, '0, '0, 0, 1);
      chk("drained_count", 64'(count), 64'(0));

      // Ack on the very edge that would otherwise time out.
      step(1, 5'h11, 32'h55, 0, 1);
      step(0, '0, '0, 0, 1);
      for (int i = 0; i < TIMEOUT - 1; i++) step(0, '0, '0, 0, 1);
      step(0, '0, '0, 1, 1);
      chk("ack_on_timeout", {62'b0, done_valid, done_ok}, 64'h3);
      for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 1);

      // Reset while a request is outstanding and three are queued.
      for (int i = 0; i < 4; i++) step(1, 5'(i + 3), 32'(i * 7), 0, 1);
      step(0, '0, '0, 0, 0);
      chk("rst_count", 64'(count), 64'(0));
      step(0, '0, '0, 0, 1);
      step(1, 5'h0A, 32'hBEEF, 0, 1);
      step(0, '0, '0, 0, 1);
      step(0, '0, '0, 1, 1);
      step(0, '0, '0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(bit'($urandom_range(0, 1)), 5'($urandom), rand_amt(),
              ($urandom_range(0, 3) == 0), 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
